rv32_alu_issue: RTL and testbench

Registered decode/operand-issue stage that drives the RV32 ALU. It accepts one fetched instruction per handshake, along with its PC and register-file read data. It decodes the instruction into an `rv_alu_op_t` opcode and two `rv_register_t` operands, then presents them to the ALU from a single pipeline register with valid/ready flow control and flush. It sits between register read and execute in the pito core.

---
 rtl/rv32_alu_issue.sv | 224 ++++++++++++++++++++++
 tb/tb_rv32_alu_issue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_alu_issue.sv
// Decode/operand-issue stage in front of the RV32 ALU: turns one fetched RV32I
// instruction plus its register reads into an ALU opcode and two operands.
package rv32_alu_pkg;
  typedef logic [31:0] rv_register_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_EQ   = 4'd10
  } rv_alu_op_t;

  typedef struct packed {
    rv_register_t rs1;
    rv_register_t rs2;
    rv_alu_op_t   op;
    logic         is_branch;
    logic         br_inv;
    logic         illegal;
  } issue_t;
endpackage

module rv32_alu_issue
  import rv32_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output rv_register_t    alu_rs1,
  output rv_register_t    alu_rs2,
  output rv_alu_op_t      alu_opcode,
  output logic            is_branch,
  output logic            br_inv,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]   opc;
  logic [2:0]   f3;
  logic [6:0]   f7;
  rv_register_t imm_i, imm_s, imm_u;
  rv_register_t shamt_reg, shamt_imm;
  issue_t       dec;
  logic         ill;

  // Register indices are consumed by the register file upstream, not here.
  logic unused_rs_idx;
  assign unused_rs_idx = ^instr[19:15];

  assign opc       = instr[6:0];
  assign f3        = instr[14:12];
  assign f7        = instr[31:25];
  assign imm_i     = {{20{instr[31]}}, instr[31:20]};
  assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u     = {instr[31:12], 12'b0};
  assign shamt_reg = {27'b0, rs2_data[4:0]};
  assign shamt_imm = {27'b0, instr[24:20]};

  always_comb begin
    dec = '0;
    ill = 1'b0;
    case (opc)
      OPC_OP: begin
        dec.rs1 = rs1_data;
        dec.rs2 = rs2_data;
        case (f3)
          3'b000: begin
            if (f7 == F7_ZERO)     dec.op = ALU_ADD;
            else if (f7 == F7_ALT) dec.op = ALU_SUB;
            else                   ill = 1'b1;
          end
          3'b001: begin
            dec.op  = ALU_SLL;
            dec.rs2 = shamt_reg;
            ill     = (f7 != F7_ZERO);
          end
          3'b010: begin dec.op = ALU_SLT;  ill = (f7 != F7_ZERO); end
          3'b011: begin dec.op = ALU_SLTU; ill = (f7 != F7_ZERO); end
          3'b100: begin dec.op = ALU_XOR;  ill = (f7 != F7_ZERO); end
          3'b101: begin
            dec.rs2 = shamt_reg;
            if (f7 == F7_ZERO)     dec.op = ALU_SRL;
            else if (f7 == F7_ALT) dec.op = ALU_SRA;
            else                   ill = 1'b1;
          end
          3'b110: begin dec.op = ALU_OR;   ill = (f7 != F7_ZERO); end
          default: begin dec.op = ALU_AND; ill = (f7 != F7_ZERO); end
        endcase
      end
      OPC_OP_IMM: begin
        dec.rs1 = rs1_data;
        dec.rs2 = imm_i;
        case (f3)
          3'b000: dec.op = ALU_ADD;
          3'b001: begin
            dec.op  = ALU_SLL;
            dec.rs2 = shamt_imm;
            ill     = (f7 != F7_ZERO);
          end
          3'b010: dec.op = ALU_SLT;
          3'b011: dec.op = ALU_SLTU;
          3'b100: dec.op = ALU_XOR;
          3'b101: begin
            dec.rs2 = shamt_imm;
            if (f7 == F7_ZERO)     dec.op = ALU_SRL;
            else if (f7 == F7_ALT) dec.op = ALU_SRA;
            else                   ill = 1'b1;
          end
          3'b110: dec.op = ALU_OR;
          default: dec.op = ALU_AND;
        endcase
      end
      OPC_LUI: dec.rs2 = imm_u;
      OPC_AUIPC: begin
        dec.rs1 = pc;
        dec.rs2 = imm_u;
      end
      OPC_LOAD: begin
        dec.rs1 = rs1_data;
        dec.rs2 = imm_i;
      end
      OPC_STORE: begin
        dec.rs1 = rs1_data;
        dec.rs2 = imm_s;
      end
      OPC_JAL, OPC_JALR: begin
        dec.rs1 = pc;
        dec.rs2 = 32'd4;
      end
      OPC_BRANCH: begin
        // Odd funct3 encodings are the inverted sense of their even partner.
        dec.rs1       = rs1_data;
        dec.rs2       = rs2_data;
        dec.is_branch = 1'b1;
        dec.br_inv    = f3[0];
        case (f3[2:1])
          2'b00:   dec.op = ALU_EQ;
          2'b10:   dec.op = ALU_SLT;
          2'b11:   dec.op = ALU_SLTU;
          default: ill = 1'b1;
        endcase
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: ill = 1'b1;
    endcase

    if (instr[1:0] != 2'b11) ill = 1'b1;

    if (ill) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  logic   out_valid_q, out_valid_d;
  issue_t issue_q, issue_d;
  logic   load;

  assign in_ready = !rst_n || !out_valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    issue_d     = issue_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      issue_d     = dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      issue_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      issue_q     <= issue_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_rs1    = issue_q.rs1;
  assign alu_rs2    = issue_q.rs2;
  assign alu_opcode = issue_q.op;
  assign is_branch  = issue_q.is_branch;
  assign br_inv     = issue_q.br_inv;
  assign illegal    = issue_q.illegal;

endmodule

// File: tb/tb_rv32_alu_issue.sv
// Bench for rv32_alu_issue: directed vectors, a behavioural issue-register
// model compared every cycle, and literal expectations for key instructions.
module tb_rv32_alu_issue;
  import rv32_alu_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [31:0]  instr = '0;
  logic [31:0]  pc = '0;
  logic [31:0]  rs1_data = '0;
  logic [31:0]  rs2_data = '0;
  logic         in_ready, out_valid, is_branch, br_inv, illegal;
  rv_register_t alu_rs1, alu_rs2;
  rv_alu_op_t   alu_opcode;

  rv32_alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_opcode(alu_opcode),
    .is_branch(is_branch), .br_inv(br_inv), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    rv_alu_op_t  op;
    logic        br;
    logic        inv;
    logic        ill;
  } exp_t;

  // What the ALU must be asked to do for one instruction, by instruction class.
  function automatic exp_t mdl(input logic [31:0] i, input logic [31:0] p,
                               input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    rv_alu_op_t  tab [8];
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_u;
    tab   = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    e     = '0;
    f3    = i[14:12];
    f7    = i[31:25];
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    imm_u = i & 32'hFFFFF000;
    case (i[6:2])
      5'b01100: begin
        e.a = x; e.b = y; e.op = tab[f3];
        if (f7 == 7'h20 && f3 == 3'd0)      e.op = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) e.op = ALU_SRA;
        else if (f7 != 7'h00)               e.ill = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) e.b = y % 32;
      end
      5'b00100: begin
        e.a = x; e.b = imm_i; e.op = tab[f3];
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.b = i[24:20];
          if (f3 == 3'd5 && f7 == 7'h20) e.op = ALU_SRA;
          else if (f7 != 7'h00)          e.ill = 1'b1;
        end
      end
      5'b01101: e.b = imm_u;
      5'b00101: begin e.a = p; e.b = imm_u; end
      5'b00000: begin e.a = x; e.b = imm_i; end
      5'b01000: begin e.a = x; e.b = imm_s; end
      5'b11011, 5'b11001: begin e.a = p; e.b = 32'd4; end
      5'b11000: begin
        e.a = x; e.b = y; e.br = 1'b1;
        case (f3)
          3'd0: e.op = ALU_EQ;
          3'd1: begin e.op = ALU_EQ;   e.inv = 1'b1; end
          3'd4: e.op = ALU_SLT;
          3'd5: begin e.op = ALU_SLT;  e.inv = 1'b1; end
          3'd6: e.op = ALU_SLTU;
          3'd7: begin e.op = ALU_SLTU; e.inv = 1'b1; end
          default: e.ill = 1'b1;
        endcase
      end
      5'b00011, 5'b11100: ;
      default: e.ill = 1'b1;
    endcase
    if (i[1:0] != 2'b11) e.ill = 1'b1;
    if (e.ill) begin
      e     = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  logic m_valid = 1'b0;
  logic m_rst = 1'b0;
  exp_t m_out = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_rst   <= 1'b1;
      m_out   <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m_rst   <= 1'b0;
      m_out   <= mdl(instr, pc, rs1_data, rs2_data);
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, !rst_n || !m_valid || out_ready);
      if (m_valid || m_rst) begin
        chk("alu_rs1", alu_rs1, m_out.a);
        chk("alu_rs2", alu_rs2, m_out.b);
        chk("alu_opcode", 32'(alu_opcode), 32'(m_out.op));
        chk("is_branch", is_branch, m_out.br);
        chk("br_inv", br_inv, m_out.inv);
        chk("illegal", illegal, m_out.ill);
      end
    end
  end

  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic ordy, input logic fl, input logic rn);
    in_valid  = iv;
    instr     = ins;
    pc        = p;
    rs1_data  = a;
    rs2_data  = b;
    out_ready = ordy;
    flush     = fl;
    rst_n     = rn;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] b2b_ins [4] = '{32'h0F014093, 32'h00509093, 32'hFFC12083, 32'h00312423};
  logic [31:0] b2b_rs2 [4] = '{32'h000000F0, 32'h00000005, 32'hFFFFFFFC, 32'h00000008};
  rv_alu_op_t  b2b_op  [4] = '{ALU_XOR, ALU_SLL, ALU_ADD, ALU_ADD};
  logic [31:0] misc    [14] = '{32'hABCDE0B7, 32'h000100E7, 32'h00209063, 32'h0020C063,
                                32'h0020A063, 32'h022081B3, 32'h00000092, 32'h0000000F,
                                32'h00000073, 32'h4030D093, 32'hFFF0B093, 32'h40009093,
                                32'h402081B3, 32'h0020E063};

  initial begin
    logic [31:0] res;
    cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk_en = 1'b1;
    cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_opcode", 32'(alu_opcode), 32'(ALU_ADD));

    // ADDI x1, x0, -1
    cyc(1'b1, 32'hFFF00093, '0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_op", 32'(alu_opcode), 32'(ALU_ADD));
    chk("addi_rs1", alu_rs1, 32'h0);
    chk("addi_rs2", alu_rs2, 32'hFFFFFFFF);
    chk("addi_illegal", illegal, 1'b0);

    // SRA x3, x1, x2: shift amount masked to 4
    cyc(1'b1, 32'h4020D1B3, '0, 32'h80000000, 32'h00000124, 1'b1, 1'b0, 1'b1);
    chk("sra_op", 32'(alu_opcode), 32'(ALU_SRA));
    chk("sra_rs2", alu_rs2, 32'h00000004);
    res = $signed(alu_rs1) >>> alu_rs2;
    chk("sra_result", res, 32'hF8000000);

    // BGEU x1, x2 with 1 < 2: not taken
    cyc(1'b1, 32'h0020F063, '0, 32'd1, 32'd2, 1'b1, 1'b0, 1'b1);
    chk("bgeu_op", 32'(alu_opcode), 32'(ALU_SLTU));
    chk("bgeu_is_branch", is_branch, 1'b1);
    chk("bgeu_br_inv", br_inv, 1'b1);
    res = (alu_rs1 < alu_rs2) ? 32'd1 : 32'd0;
    chk("bgeu_res", res, 32'd1);
    chk("bgeu_taken", (res[0] == 1'b0) == br_inv, 1'b0);

    // AUIPC x5, 0x12345 at pc 0x100
    cyc(1'b1, 32'h12345297, 32'h100, '0, '0, 1'b1, 1'b0, 1'b1);
    chk("auipc_rs1", alu_rs1, 32'h100);
    chk("auipc_rs2", alu_rs2, 32'h12345000);
    chk("auipc_op", 32'(alu_opcode), 32'(ALU_ADD));

    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, b2b_ins[0], '0, 32'h11, 32'h22, 1'b0, 1'b0, 1'b1);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_rs2_frozen", alu_rs2, 32'h12345000);
      chk("stall_rs1_frozen", alu_rs1, 32'h100);
    end

    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, b2b_ins[k], '0, 32'h40 + k, 32'h3F, 1'b1, 1'b0, 1'b1);
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_rs2", alu_rs2, b2b_rs2[k]);
      chk("b2b_op", 32'(alu_opcode), 32'(b2b_op[k]));
      chk("b2b_rs1", alu_rs1, 32'h40 + k);
    end

    // Flush with a held entry and a new offer
    cyc(1'b1, 32'hABCDE0B7, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("pre_flush_valid", out_valid, 1'b1);
    cyc(1'b1, 32'hABCDE0B7, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    chk("flush_valid", out_valid, 1'b0);

    // JAL at pc 0x200, then reset while stalled
    cyc(1'b1, 32'h008000EF, 32'h200, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("jal_rs1", alu_rs1, 32'h200);
    chk("jal_rs2", alu_rs2, 32'd4);
    cyc(1'b1, 32'hFFF00093, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("jal_stall_in_ready", in_ready, 1'b0);
    cyc(1'b1, 32'hFFF00093, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_stall_valid", out_valid, 1'b0);
    chk("rst_stall_in_ready", in_ready, 1'b1);
    chk("rst_stall_rs1", alu_rs1, 32'h0);
    chk("rst_stall_rs2", alu_rs2, 32'h0);
    chk("rst_stall_op", 32'(alu_opcode), 32'(ALU_ADD));

    // All-ones word is illegal but still issued
    cyc(1'b1, 32'hFFFFFFFF, 32'h300, 32'd5, 32'd6, 1'b1, 1'b0, 1'b1);
    chk("ill_valid", out_valid, 1'b1);
    chk("ill_flag", illegal, 1'b1);
    chk("ill_op", 32'(alu_opcode), 32'(ALU_ADD));
    chk("ill_rs1", alu_rs1, 32'h0);
    chk("ill_rs2", alu_rs2, 32'h0);

    for (int k = 0; k < 14; k++)
      cyc(1'b1, misc[k], 32'h400 + 4 * k, 32'h1000 + k, 32'hA5 + k, (k % 3) != 0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++)
      cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
